// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmit byte channel between N_REQ producers. Requesters are
// served one byte at a time in round-robin order. A single holding register
// keeps the byte on UART_TX until the UART consumes it. tx_count records
// completed bytes and wraps at 2^CNT_W.
//
// Optional build macro: UART_TX_ARB_LOCK_EN
//   Adds the req_last input. After a byte completes with req_last=0, the grant
//   stays with the same requester until a byte with req_last=1 completes, so
//   multi-byte messages reach the UART unbroken.
//
// state  | meaning
// S_IDLE | nothing held; choose a requester and accept its byte this cycle
// S_SEND | byte held on UART_TX with valid high; wait for UART_TX_ready

module uart_tx_arbiter #(
  parameter int N_REQ = 2,
  parameter int CNT_W = 16,
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]   req_last,
`endif
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         UART_TX,
  output logic               UART_TX_valid,
  input  logic               UART_TX_ready,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic [CNT_W-1:0]   tx_count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [GW-1:0]      r_last_grant;
  logic [GW-1:0]      r_grant;
  logic [7:0]         r_tx;
  logic [CNT_W-1:0]   r_count;

  logic               w_any;
  logic [GW-1:0]      w_pick;
  logic [7:0]         w_byte;
  logic               w_accept;
  logic               w_complete;
  logic [N_REQ-1:0]   w_ready;

`ifdef UART_TX_ARB_LOCK_EN
  logic               r_lock;
  logic               r_lock_last;
`endif

  // Index base+step, reduced modulo N_REQ without a divider (step <= N_REQ).
  function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= N_REQ) s = s - N_REQ;
    return GW'(s);
  endfunction

  // Round-robin search starting just after the last completed grant; a held
  // lock restricts eligibility to the current owner.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_any && req_valid[rr_index(r_last_grant, k)]) begin
        w_any  = 1'b1;
        w_pick = rr_index(r_last_grant, k);
      end
    end
`ifdef UART_TX_ARB_LOCK_EN
    if (r_lock) begin
      w_any  = req_valid[r_grant];
      w_pick = r_grant;
    end
`endif
  end

  assign w_byte = req_data[{w_pick, 3'b000} +: 8];

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus the accept/complete strobes and the combinational ready.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_ready     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_accept        = 1'b1;
          w_ready[w_pick] = 1'b1;
          w_state_nxt     = S_SEND;
        end
      end
      S_SEND: begin
        if (UART_TX_ready) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Holding register and owner index, loaded on accept and stable in SEND.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tx    <= 8'h00;
      r_grant <= '0;
    end else if (w_accept) begin
      r_tx    <= w_byte;
      r_grant <= w_pick;
    end
  end

  // Round-robin pointer and byte counter advance only when the UART takes a byte.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_last_grant <= GW'(N_REQ - 1);
      r_count      <= '0;
    end else if (w_complete) begin
      r_last_grant <= r_grant;
      r_count      <= r_count + CNT_W'(1);
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  // Message lock: remember req_last of the held byte, lock on completion if the
  // message is not finished.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_lock      <= 1'b0;
      r_lock_last <= 1'b1;
    end else begin
      if (w_accept)   r_lock_last <= req_last[w_pick];
      if (w_complete) r_lock      <= ~r_lock_last;
    end
  end
`endif

  // Valid and busy come straight from the state flop so reset drops them at once.
  assign UART_TX_valid = (r_state == S_SEND);
  assign busy          = (r_state == S_SEND);
  assign UART_TX       = r_tx;
  assign grant_id      = r_grant;
  assign tx_count      = r_count;
  assign req_ready     = w_ready;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (N_REQ=3, CNT_W=4). A byte-level model predicts all
// outputs every cycle; literal expectations pin the UART byte order and counts.
// Build with UART_TX_ARB_LOCK_EN defined to also exercise message locking.

module tb_uart_tx_arbiter;
  localparam int N  = 3;
  localparam int CW = 4;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N-1:0]   req_last = '0;
`endif
  logic           UART_TX_ready = 1'b0;
  logic [N-1:0]   req_ready;
  logic [7:0]     UART_TX;
  logic           UART_TX_valid;
  logic [1:0]     grant_id;
  logic           busy;
  logic [CW-1:0]  tx_count;

  uart_tx_arbiter #(.N_REQ(N), .CNT_W(CW)) u_dut (
    .CLK(CLK),
    .RESET(RESET),
    .req_valid(req_valid),
    .req_data(req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .req_last(req_last),
`endif
    .req_ready(req_ready),
    .UART_TX(UART_TX),
    .UART_TX_valid(UART_TX_valid),
    .UART_TX_ready(UART_TX_ready),
    .grant_id(grant_id),
    .busy(busy),
    .tx_count(tx_count)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  logic [7:0] dut_sent[$];
  logic [7:0] exp_q[$];

  // Byte-level model: is a byte held, which byte/owner, rr pointer, count, lock.
  int         m_busy, m_gid, m_last, m_count, m_lock, m_lastbit;
  logic [7:0] m_byte;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_seq(input string nm);
    check({nm, "_len"}, dut_sent.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dut_sent.size(); i++)
      check(nm, 32'(dut_sent[i]), 32'(exp_q[i]));
  endtask

  // Winner among valid requesters: owner only when locked, else the first one
  // after the last completed grant, cyclically. -1 when nobody is eligible.
  function automatic int model_pick();
    if (m_lock != 0) return req_valid[m_gid] ? m_gid : -1;
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge CLK or posedge RESET) begin : model
    int p;
    if (RESET) begin
      m_busy = 0; m_byte = 8'h00; m_gid = 0; m_last = N - 1;
      m_count = 0; m_lock = 0; m_lastbit = 1;
    end else begin
      if (UART_TX_valid && UART_TX_ready) dut_sent.push_back(UART_TX);
      if (m_busy != 0) begin
        if (UART_TX_ready) begin
          m_busy  = 0;
          m_last  = m_gid;
          m_count = (m_count + 1) % (1 << CW);
`ifdef UART_TX_ARB_LOCK_EN
          m_lock  = (m_lastbit == 0) ? 1 : 0;
`endif
        end
      end else begin
        p = model_pick();
        if (p >= 0) begin
          m_busy = 1;
          m_gid  = p;
          m_byte = req_data[p*8 +: 8];
`ifdef UART_TX_ARB_LOCK_EN
          m_lastbit = req_last[p] ? 1 : 0;
`endif
        end
      end
    end
  end

  always @(negedge CLK) begin : compare
    int p;
    int exp_rr;
    if (!RESET) begin
      p = model_pick();
      exp_rr = (m_busy == 0 && p >= 0) ? (1 << p) : 0;
      check("req_ready", 32'(req_ready), 32'(exp_rr));
      check("UART_TX_valid", 32'(UART_TX_valid), 32'(m_busy));
      check("busy", 32'(busy), 32'(m_busy));
      check("UART_TX", 32'(UART_TX), 32'(m_byte));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      check("tx_count", 32'(tx_count), 32'(m_count));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    UART_TX_ready = 1'b0;
    #1 RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    dut_sent.delete();
  endtask

  initial begin
    tick(2);
    RESET = 1'b0;
    check("rst_valid", 32'(UART_TX_valid), 32'd0);
    check("rst_count", 32'(tx_count), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_tx", 32'(UART_TX), 32'd0);

    // single requester
    req_data[7:0] = 8'h41; req_valid = 3'b001; UART_TX_ready = 1'b1;
    #1 check("single_ready", 32'(req_ready), 32'b001);
    tick(1);
    req_valid = '0;
    check("single_valid", 32'(UART_TX_valid), 32'd1);
    check("single_tx", 32'(UART_TX), 32'h41);
    tick(1);
    check("single_drop", 32'(UART_TX_valid), 32'd0);
    check("single_count", 32'(tx_count), 32'd1);
    tick(2);
    check("idle_ready_ignored", 32'(tx_count), 32'd1);

    // two-way contention from reset
    do_reset();
    req_data[7:0] = 8'h10; req_data[15:8] = 8'h20; req_valid = 3'b011; UART_TX_ready = 1'b1;
    tick(8);
    req_valid = '0;
    tick(1);
    exp_q = '{8'h10, 8'h20, 8'h10, 8'h20};
    check_seq("contention");
    check("contention_count", 32'(tx_count), 32'd4);

    // three-way contention continuing from last grant = 1
    dut_sent.delete();
    req_data = {8'hC2, 8'hB1, 8'hA0}; req_valid = 3'b111;
    tick(6);
    req_valid = '0;
    tick(1);
    exp_q = '{8'hC2, 8'hA0, 8'hB1};
    check_seq("three_way");

    // backpressure
    dut_sent.delete();
    UART_TX_ready = 1'b0;
    req_data[7:0] = 8'h55; req_valid = 3'b001;
    tick(1);
    req_data[15:8] = 8'h66; req_valid = 3'b010;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(UART_TX_valid), 32'd1);
      check("bp_tx", 32'(UART_TX), 32'h55);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
      tick(1);
    end
    UART_TX_ready = 1'b1;
    tick(2);
    req_valid = '0;
    tick(1);
    exp_q = '{8'h55, 8'h66};
    check_seq("backpressure");
    check("bp_count", 32'(tx_count), 32'd9);

    // reset in the middle of SEND
    dut_sent.delete();
    UART_TX_ready = 1'b0;
    req_data[15:8] = 8'h7E; req_valid = 3'b010;
    tick(1);
    check("pre_rst_tx", 32'(UART_TX), 32'h7E);
    req_data[7:0] = 8'h11; req_valid = 3'b011;
    RESET = 1'b1;
    #1;
    check("midrst_valid", 32'(UART_TX_valid), 32'd0);
    check("midrst_count", 32'(tx_count), 32'd0);
    tick(1);
    RESET = 1'b0;
    UART_TX_ready = 1'b1;
    #1 check("post_rst_ready", 32'(req_ready), 32'b001);
    tick(1);
    check("post_rst_grant", 32'(grant_id), 32'd0);
    check("post_rst_tx", 32'(UART_TX), 32'h11);
    req_valid = 3'b010;
    tick(2);
    req_valid = '0;
    tick(1);
    exp_q = '{8'h11, 8'h7E};
    check_seq("after_reset");
    check("after_reset_count", 32'(tx_count), 32'd2);

    // counter wrap: 17 bytes at CNT_W=4
    do_reset();
    req_data[7:0] = 8'h5A; req_valid = 3'b001; UART_TX_ready = 1'b1;
    tick(34);
    req_valid = '0;
    tick(2);
    check("wrap_bytes", dut_sent.size(), 32'd17);
    check("wrap_count", 32'(tx_count), 32'd1);

`ifdef UART_TX_ARB_LOCK_EN
    // locked message "AB" from req0 while req1 waits
    do_reset();
    req_data[7:0] = 8'h41; req_data[15:8] = 8'h31; req_last = 3'b000;
    req_valid = 3'b011; UART_TX_ready = 1'b1;
    tick(1);
    req_data[7:0] = 8'h42; req_last = 3'b001;
    tick(1);
    check("lock_hold_ready", 32'(req_ready), 32'b001);
    tick(1);
    req_valid = 3'b010; req_last = 3'b000;
    tick(2);
    req_valid = '0;
    tick(2);
    exp_q = '{8'h41, 8'h42, 8'h31};
    check_seq("lock_order");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
